// File: rtl/rom_rd_stream_pkg.sv
// Shared types and helpers for the ROM burst read engine.
// Holds the FSM encoding, default widths and the buffer-credit arithmetic.
package rom_rd_stream_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A new read may go out only if, after this cycle's pop, fewer than two words
  // are buffered or returning from the ROM, so the 2-entry buffer never overflows.
  function automatic logic can_issue(input logic [1:0] cnt, input logic infl,
                                     input logic pop);
    logic [2:0] held;
    held = {1'b0, cnt} + {2'b00, infl};
    return held < (3'd2 + {2'b00, pop});
  endfunction

  function automatic logic drains_now(input logic [1:0] cnt, input logic infl,
                                      input logic pop);
    return !infl && ((cnt == 2'd0) || ((cnt == 2'd1) && pop));
  endfunction

endpackage

// File: rtl/rom_rd_stream_if.sv
// Valid/ready word stream carrying ROM burst data and an end-of-burst marker.
interface rom_rd_stream_if #(
  parameter int Word_Width = 32
) ();
  logic                  val;
  logic                  rdy;
  logic [Word_Width-1:0] dat;
  logic                  last;

  modport master (output val, output dat, output last, input  rdy);
  modport slave  (input  val, input  dat, input  last, output rdy);
endinterface

// File: rtl/rom_rd_skid.sv
// Two-entry FIFO holding returned ROM words plus their last flag.
// Push and pop may coincide at any occupancy, including full.
module rom_rd_skid #(
  parameter int Word_Width = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic [Word_Width:0] i_data,
  input  logic                i_pop,
  output logic [Word_Width:0] o_data,
  output logic [1:0]          o_cnt,
  output logic                o_full,
  output logic                o_empty
);

  logic [Word_Width:0] r_mem [2];
  logic                r_wr;
  logic                r_rd;
  logic [1:0]          r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_wr <= ~r_wr;
      if (i_pop)  r_rd <= ~r_rd;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is data only; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/rom_rd_stream.sv
// Burst read engine for a 1-cycle-latency single-port ROM: issues LEN reads from
// BASE (address wraps) and streams the words out through a 2-entry skid buffer.
module rom_rd_stream
  import rom_rd_stream_pkg::*;
#(
  parameter int Word_Width = WORD_W_DEF,
  parameter int Addr_Width = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [Addr_Width-1:0] base_addr_i,
  input  logic [Addr_Width:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rom_cen_o,
  output logic                  rom_oen_o,
  output logic [Addr_Width-1:0] rom_addr_o,
  input  logic [Word_Width-1:0] rom_data_i,
  rom_rd_stream_if.master       strm
);

  localparam logic [Addr_Width:0] IDX_ONE = {{Addr_Width{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [Addr_Width-1:0] r_base;
  logic [Addr_Width:0]   r_len;
  logic [Addr_Width:0]   r_idx;
  logic                  r_infl;
  logic                  r_infl_last;

  logic                  w_pop;
  logic                  w_issue;
  logic                  w_issue_last;
  logic [Word_Width:0]   w_head;
  logic [1:0]            w_cnt;
  logic                  w_full;
  logic                  w_empty;

  assign w_pop        = !w_empty && strm.rdy;
  assign w_issue      = (r_state == ST_RUN) && !(w_full && !w_pop) &&
                        can_issue(w_cnt, r_infl, w_pop);
  assign w_issue_last = w_issue && ((r_idx + IDX_ONE) == r_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_infl      <= w_issue;
      r_infl_last <= w_issue_last;
      if ((r_state == ST_IDLE) && start_i) begin
        r_base <= base_addr_i;
        r_len  <= len_i;
        r_idx  <= '0;
      end else if (w_issue) begin
        r_idx  <= r_idx + IDX_ONE;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_nxt = (len_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_issue_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (drains_now(w_cnt, r_infl, w_pop)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = (r_state == ST_DONE);
  assign rom_cen_o  = !w_issue;
  assign rom_oen_o  = !((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign rom_addr_o = r_base + r_idx[Addr_Width-1:0];

  // The word read last cycle lands in the buffer at this edge.
  rom_rd_skid #(.Word_Width(Word_Width)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_infl),
    .i_data  ({r_infl_last, rom_data_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_cnt   (w_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign strm.val  = !w_empty;
  assign strm.dat  = w_empty ? '0 : w_head[Word_Width-1:0];
  assign strm.last = !w_empty && w_head[Word_Width];

endmodule

// File: tb/tb_rom_rd_stream.sv
// Scoreboard bench for rom_rd_stream with an inline 1-cycle-latency ROM model.
module tb_rom_rd_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base = 8'h00;
  logic [8:0]  len = 9'd0;
  logic        busy, done, cen, oen;
  logic [7:0]  addr;
  logic [31:0] rom_data;
  logic [31:0] rom_q = 32'h0;
  logic [31:0] mem [256];
  logic        rdy = 1'b1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] exp_q [$];

  rom_rd_stream_if #(.Word_Width(32)) s_if ();
  assign s_if.rdy = rdy;

  rom_rd_stream #(.Word_Width(32), .Addr_Width(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .rom_cen_o   (cen),
    .rom_oen_o   (oen),
    .rom_addr_o  (addr),
    .rom_data_i  (rom_data),
    .strm        (s_if)
  );

  always #5 clk = ~clk;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'hA500_0000 | a;
  end
  always @(posedge clk) if (!cen) rom_q <= mem[addr];
  assign rom_data = oen ? 32'h0 : rom_q;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold-while-stalled
  // and that issued-but-unconsumed words never exceed the two buffer slots.
  logic        mon_hold = 1'b0;
  logic [32:0] mon_hold_w = '0;
  logic [32:0] mon_exp;
  int          outst = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_hold) begin
        check("hold_val", s_if.val, 1);
        check("hold_word", {s_if.last, s_if.dat}, mon_hold_w);
      end
      if (s_if.val && s_if.rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %h expected none at %0t",
                   {s_if.last, s_if.dat}, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", {s_if.last, s_if.dat}, mon_exp);
        end
      end
      outst = outst + (cen ? 0 : 1) - ((s_if.val && s_if.rdy) ? 1 : 0);
      if (!cen) check("credit_le2", outst <= 2, 1);
      if (rst) outst = 0;
      mon_hold   = s_if.val && !s_if.rdy && !rst;
      mon_hold_w = {s_if.last, s_if.dat};
    end
  end

  task automatic start_burst(input logic [7:0] b, input logic [8:0] l, input int nexp);
    for (int i = 0; i < nexp; i++)
      exp_q.push_back({(i == int'(l) - 1), mem[8'(int'(b) + i)]});
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check(nm, seen, 1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_val"},  s_if.val, 0);
    check({pfx, "_last"}, s_if.last, 0);
    check({pfx, "_cen"},  cen, 1);
    check({pfx, "_oen"},  oen, 1);
    check({pfx, "_addr"}, addr, 0);
    check({pfx, "_dat"},  s_if.dat, 0);
  endtask

  initial begin
    logic [7:0] cen_e, val_e, done_e, busy_e, oen_e;
    logic [7:0] got_addr [4];
    logic [3:0] pat;
    logic       seen;
    int         na;
    int         npulse;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    @(posedge clk); #1 rst = 1'b0;

    // 1: base 0x10, len 4, always ready; cycle-exact timing
    cen_e  = 8'b1111_0000;
    val_e  = 8'b0011_1100;
    done_e = 8'b0100_0000;
    busy_e = 8'b0111_1111;
    oen_e  = 8'b1100_0000;
    start_burst(8'h10, 9'd4, 4);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("t1_cen%0d", j),  cen, cen_e[j]);
      check($sformatf("t1_val%0d", j),  s_if.val, val_e[j]);
      check($sformatf("t1_done%0d", j), done, done_e[j]);
      check($sformatf("t1_busy%0d", j), busy, busy_e[j]);
      check($sformatf("t1_oen%0d", j),  oen, oen_e[j]);
      if (j < 4) check($sformatf("t1_addr%0d", j), addr, 8'h10 + 8'(j));
    end
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: address wrap past the top of the ROM
    start_burst(8'hFE, 9'd4, 4);
    na = 0;
    for (int i = 0; i < 20 && na < 4; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      if (!cen) begin got_addr[na] = addr; na++; end
    end
    check("t2_naddr", na, 4);
    check("t2_addr0", got_addr[0], 8'hFE);
    check("t2_addr1", got_addr[1], 8'hFF);
    check("t2_addr2", got_addr[2], 8'h00);
    check("t2_addr3", got_addr[3], 8'h01);
    wait_done("t2_done", 30);
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: len 8 with ready pattern 1,0,0,1
    pat = 4'b1001;
    start_burst(8'h30, 9'd8, 8);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      rdy = pat[i % 4];
      if (done) begin seen = 1'b1; break; end
    end
    rdy = 1'b1;
    check("t3_done", seen, 1);
    check("t3_sb_empty", exp_q.size(), 0);

    // 4: zero-length burst
    @(posedge clk);
    start_burst(8'h55, 9'd0, 0);
    npulse = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("t4_cen%0d", j), cen, 1);
      check($sformatf("t4_val%0d", j), s_if.val, 0);
      if (done) npulse++;
      if (j == 0) check("t4_done_first", done, 1);
    end
    check("t4_npulse", npulse, 1);

    // 5: restart mid-burst is ignored; stalled consumer throttles issue
    rdy = 1'b0;
    start_burst(8'h50, 9'd8, 8);
    repeat (4) @(negedge clk);
    check("t5_nocredit_cen", cen, 1);
    check("t5_val", s_if.val, 1);
    @(posedge clk); #1;
    start = 1'b1; base = 8'h40; len = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    rdy = 1'b1;
    wait_done("t5_done", 40);
    check("t5_sb_empty", exp_q.size(), 0);

    // 6: reset while the third word is presented, then a fresh burst
    start_burst(8'h60, 9'd8, 3);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("t6");
    check("t6_sb_empty", exp_q.size(), 0);
    start_burst(8'h20, 9'd2, 2);
    wait_done("t6_done", 30);
    check("t6_sb_empty2", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
